// File: rtl/hero_write_rx.sv
// hero_write_rx: receive endpoint of the hero write bus.
// It samples framed beats from the hero bus and checks their framing. Beats are
// buffered in a DEPTH-entry FIFO. The FIFO head is presented to a downstream
// consumer on a valid/ready stream, tagged with beat index, last and abort flags.
module hero_write_rx #(
  parameter int DEPTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   hero_cycle_type,
  input  logic [35:0]                  hero_wdat,
  input  logic [6:0]                   hero_sub,
  input  logic                         hero_clk_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [35:0]                  out_wdat,
  output logic [6:0]                   out_sub,
  output logic [$clog2(MAX_BEATS)-1:0] out_beat_idx,
  output logic                         out_last,
  output logic                         out_abort,
  output logic                         err_overflow,
  output logic                         err_protocol,
  output logic [15:0]                  txn_count
);

  localparam int DATA_W = 36;
  localparam int SUB_W  = 7;
  localparam int IW     = $clog2(MAX_BEATS);
  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = AW + 1;

  typedef enum logic [1:0] {
    CYC_IDLE    = 2'd0,
    CYC_VALID   = 2'd1,
    CYC_DONE    = 2'd2,
    CYC_ILLEGAL = 2'd3
  } cycle_type_e;

  typedef enum logic [1:0] {
    IDLE_S   = 2'd0,
    IN_TXN_S = 2'd1,
    DROP_S   = 2'd2
  } state_t;

  typedef struct packed {
    logic              abort;
    logic              last;
    logic [IW-1:0]     idx;
    logic [SUB_W-1:0]  sub;
    logic [DATA_W-1:0] wdat;
  } entry_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          pending_abort;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count;
  entry_t        mem [DEPTH];
  entry_t        head;
  entry_t        push_entry;

  logic push;
  logic pop;
  logic full;
  logic beat;
  logic is_done;
  logic illegal;
  logic blocked;
  logic beat_ovf;
  logic beat_ok;
  logic at_max;
  logic marker_go;

  assign count     = wr_ptr - rd_ptr;
  assign full      = (count == PW'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign head      = mem[rd_ptr[AW-1:0]];

  // Head fields are forced to zero when the FIFO is empty so that reset is visible at once.
  always_comb begin
    out_wdat     = '0;
    out_sub      = '0;
    out_beat_idx = '0;
    out_last     = 1'b0;
    out_abort    = 1'b0;
    if (out_valid) begin
      out_wdat     = head.wdat;
      out_sub      = head.sub;
      out_beat_idx = head.idx;
      out_last     = head.last;
      out_abort    = head.abort;
    end
  end

  // Decode the sampled cycle and choose at most one FIFO push; a pending marker wins the slot.
  always_comb begin
    beat       = hero_clk_en && ((hero_cycle_type == CYC_VALID) || (hero_cycle_type == CYC_DONE));
    is_done    = (hero_cycle_type == CYC_DONE);
    illegal    = hero_clk_en && (hero_cycle_type == CYC_ILLEGAL);
    at_max     = (idx == IW'(MAX_BEATS - 1));
    marker_go  = pending_abort && !full;
    blocked    = full || pending_abort;
    beat_ovf   = beat && (state != DROP_S) && blocked;
    beat_ok    = beat && (state != DROP_S) && !blocked;
    push       = 1'b0;
    push_entry = '0;
    if (marker_go) begin
      push             = 1'b1;
      push_entry.abort = 1'b1;
      push_entry.last  = 1'b1;
    end else if (beat_ok) begin
      push            = 1'b1;
      push_entry.wdat = hero_wdat;
      push_entry.sub  = hero_sub;
      push_entry.idx  = (state == IDLE_S) ? '0 : idx;
      push_entry.last = is_done || ((state == IN_TXN_S) && at_max);
    end
  end

  // Beat storage is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  // Framing FSM, FIFO pointers, abort bookkeeping, error pulses and transaction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE_S;
      idx           <= '0;
      pending_abort <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      err_overflow  <= 1'b0;
      err_protocol  <= 1'b0;
      txn_count     <= '0;
    end else begin
      err_overflow <= beat_ovf;
      err_protocol <= illegal || (beat_ok && (state == IN_TXN_S) && !is_done && at_max);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (marker_go) pending_abort <= 1'b0;
      // An overflow caused only by a still-pending marker must not re-arm it.
      if (beat_ovf && !pending_abort) pending_abort <= 1'b1;
      if (beat) begin
        case (state)
          IDLE_S: begin
            if (beat_ovf) begin
              state <= DROP_S;
            end else if (is_done) begin
              txn_count <= txn_count + 16'd1;
            end else begin
              state <= IN_TXN_S;
              idx   <= IW'(1);
            end
          end
          IN_TXN_S: begin
            if (beat_ovf) begin
              state <= DROP_S;
            end else if (is_done) begin
              state     <= IDLE_S;
              txn_count <= txn_count + 16'd1;
            end else if (at_max) begin
              state <= DROP_S;
            end else begin
              idx <= idx + IW'(1);
            end
          end
          default: begin
            if (is_done) state <= IDLE_S;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hero_write_rx.sv
// tb_hero_write_rx: table-driven bench with an output scoreboard for hero_write_rx.
module tb_hero_write_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  hero_cycle_type;
  logic [35:0] hero_wdat;
  logic [6:0]  hero_sub;
  logic        hero_clk_en;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] out_wdat;
  logic [6:0]  out_sub;
  logic [3:0]  out_beat_idx;
  logic        out_last;
  logic        out_abort;
  logic        err_overflow;
  logic        err_protocol;
  logic [15:0] txn_count;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] IDL = 2'd0, VAL = 2'd1, DON = 2'd2, ILL = 2'd3;

  typedef struct {
    logic [1:0]  ct;
    logic        en;
    logic [35:0] wdat;
    logic [6:0]  sub;
    logic        rdy;
    logic        push;
    logic [3:0]  idx;
    logic        last;
    logic        ovf;
    logic        proto;
    int          txn;
  } vec_t;

  typedef struct {
    logic [35:0] wdat;
    logic [6:0]  sub;
    logic [3:0]  idx;
    logic        last;
    logic        abort;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  hero_write_rx #(.DEPTH(8), .MAX_BEATS(16)) dut (
    .clk(clk), .rst(rst),
    .hero_cycle_type(hero_cycle_type), .hero_wdat(hero_wdat),
    .hero_sub(hero_sub), .hero_clk_en(hero_clk_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wdat(out_wdat), .out_sub(out_sub), .out_beat_idx(out_beat_idx),
    .out_last(out_last), .out_abort(out_abort),
    .err_overflow(err_overflow), .err_protocol(err_protocol),
    .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void add(input logic [1:0] ct, input logic en, input logic [35:0] wdat,
                              input logic [6:0] sub, input logic rdy, input logic push,
                              input logic [3:0] idx, input logic last, input logic ovf,
                              input logic proto, input int txn);
    vec_t v;
    v.ct = ct; v.en = en; v.wdat = wdat; v.sub = sub; v.rdy = rdy;
    v.push = push; v.idx = idx; v.last = last; v.ovf = ovf; v.proto = proto; v.txn = txn;
    vecs.push_back(v);
  endfunction

  task automatic idle_inputs(input logic rdy);
    hero_cycle_type = IDL;
    hero_wdat       = '0;
    hero_sub        = '0;
    hero_clk_en     = 1'b1;
    out_ready       = rdy;
  endtask

  task automatic run_table();
    exp_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].push) begin
        e.wdat = vecs[i].wdat; e.sub = vecs[i].sub; e.idx = vecs[i].idx;
        e.last = vecs[i].last; e.abort = 1'b0;
        exp_q.push_back(e);
      end
      hero_cycle_type = vecs[i].ct;
      hero_clk_en     = vecs[i].en;
      hero_wdat       = vecs[i].wdat;
      hero_sub        = vecs[i].sub;
      out_ready       = vecs[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("err_overflow_row%0d", i), 64'(err_overflow), 64'(vecs[i].ovf));
      chk($sformatf("err_protocol_row%0d", i), 64'(err_protocol), 64'(vecs[i].proto));
      chk($sformatf("txn_count_row%0d", i), 64'(txn_count), 64'(vecs[i].txn));
    end
    vecs.delete();
    idle_inputs(out_ready);
  endtask

  task automatic push_marker();
    exp_t e;
    e.wdat = '0; e.sub = '0; e.idx = '0; e.last = 1'b1; e.abort = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    idle_inputs(1'b1);
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_left_in_scoreboard"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_out_valid_idle"}, 64'(out_valid), 64'd0);
  endtask

  // Scoreboard: every accepted output beat is compared with the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat actual=wdat %0h idx %0d last %0b abort %0b required=none",
                 out_wdat, out_beat_idx, out_last, out_abort);
      end else begin
        e = exp_q.pop_front();
        chk("out_wdat", 64'(out_wdat), 64'(e.wdat));
        chk("out_sub", 64'(out_sub), 64'(e.sub));
        chk("out_beat_idx", 64'(out_beat_idx), 64'(e.idx));
        chk("out_last", 64'(out_last), 64'(e.last));
        chk("out_abort", 64'(out_abort), 64'(e.abort));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs(1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_wdat", 64'(out_wdat), 64'd0);
    chk("reset_out_last", 64'(out_last), 64'd0);
    chk("reset_err_overflow", 64'(err_overflow), 64'd0);
    chk("reset_err_protocol", 64'(err_protocol), 64'd0);
    chk("reset_txn_count", 64'(txn_count), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single-beat transaction
    add(DON, 1, 36'h123456789, 7'h15, 1, 1, 0, 1, 0, 0, 1);
    add(IDL, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    run_table();
    wait_drain("single");

    // Multi-beat with an IDLE bubble and a gated DONE
    add(VAL, 1, 36'hA0000000A, 7'h01, 1, 1, 0, 0, 0, 0, 1);
    add(IDL, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    add(DON, 0, 36'hDEADBEEF0, 7'h7F, 1, 0, 0, 0, 0, 0, 1);
    add(VAL, 1, 36'hB0000000B, 7'h02, 1, 1, 1, 0, 0, 0, 1);
    add(DON, 1, 36'hC0000000C, 7'h03, 1, 1, 2, 1, 0, 0, 2);
    run_table();
    wait_drain("multi");

    // MAX_BEATS exceeded: beat 16 closes with last, the rest is dropped
    for (int k = 0; k < 16; k++)
      add(VAL, 1, 36'h200000000 + 36'(k), 7'(k), 1, 1, 4'(k), (k == 15), 0, (k == 15), 2);
    add(VAL, 1, 36'h2FFFFFFFF, 7'h55, 1, 0, 0, 0, 0, 0, 2);
    add(DON, 1, 36'h2EEEEEEEE, 7'h66, 1, 0, 0, 0, 0, 0, 2);
    add(IDL, 1, 0, 0, 1, 0, 0, 0, 0, 0, 2);
    run_table();
    wait_drain("max_beats");

    // Illegal encoding mid-transaction is ignored apart from the error pulse
    add(VAL, 1, 36'h300000001, 7'h11, 1, 1, 0, 0, 0, 0, 2);
    add(ILL, 1, 36'h3FFFFFFFF, 7'h22, 1, 0, 0, 0, 0, 1, 2);
    add(VAL, 1, 36'h300000002, 7'h33, 1, 1, 1, 0, 0, 0, 2);
    add(DON, 1, 36'h300000003, 7'h44, 1, 1, 2, 1, 0, 0, 3);
    run_table();
    wait_drain("illegal");

    // Overflow with the consumer stalled: 8 stored, one error pulse, marker after drain
    for (int k = 0; k < 10; k++)
      add(VAL, 1, 36'h400000000 + 36'(k), 7'(k + 8), 0, (k < 8), 4'(k), 0, (k == 8), 0, 3);
    add(DON, 1, 36'h4DDDDDDDD, 7'h5A, 0, 0, 0, 0, 0, 0, 3);
    add(IDL, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    run_table();
    chk("overflow_fifo_held", 64'(out_valid), 64'd1);
    push_marker();
    wait_drain("overflow");

    // Full FIFO with a pop in the same cycle as a new beat: the beat is still rejected
    for (int k = 0; k < 8; k++)
      add(VAL, 1, 36'h500000000 + 36'(k), 7'(k), 0, 1, 4'(k), 0, 0, 0, 3);
    add(VAL, 1, 36'h5CCCCCCCC, 7'h6C, 1, 0, 0, 0, 1, 0, 3);
    add(DON, 1, 36'h5DDDDDDDD, 7'h6D, 1, 0, 0, 0, 0, 0, 3);
    run_table();
    push_marker();
    wait_drain("push_pop_full");

    // Asynchronous reset with three beats buffered
    for (int k = 0; k < 3; k++)
      add(VAL, 1, 36'h600000000 + 36'(k), 7'(k), 0, 0, 0, 0, 0, 0, 3);
    run_table();
    chk("pre_reset_out_valid", 64'(out_valid), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_out_wdat", 64'(out_wdat), 64'd0);
    chk("async_rst_out_sub", 64'(out_sub), 64'd0);
    chk("async_rst_out_beat_idx", 64'(out_beat_idx), 64'd0);
    chk("async_rst_out_last", 64'(out_last), 64'd0);
    chk("async_rst_out_abort", 64'(out_abort), 64'd0);
    chk("async_rst_txn_count", 64'(txn_count), 64'd0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    add(VAL, 1, 36'h700000000, 7'h70, 1, 1, 0, 0, 0, 0, 0);
    add(DON, 1, 36'h700000001, 7'h71, 1, 1, 1, 1, 0, 0, 1);
    add(IDL, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    run_table();
    wait_drain("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
